// File: rtl/nes_pad_pkg.sv
// Shared types and constants for the two-player NES pad poller.
package nes_pad_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NBITS = 8;

    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

endpackage

// File: rtl/nes_poll_timer.sv
// Free-running auto-poll timer: one-cycle fire pulse every POLL_PERIOD_CYC clocks while enabled.
module nes_poll_timer #(
    parameter int POLL_PERIOD_CYC = 200000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic auto_en,
    output logic fire
);

    localparam int CW = $clog2(POLL_PERIOD_CYC);
    localparam logic [CW-1:0] LAST = CW'(POLL_PERIOD_CYC - 1);

    logic [CW-1:0] count;

    // fire is registered, so it lands exactly POLL_PERIOD_CYC cycles after enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            fire  <= 1'b0;
        end else if (!auto_en) begin
            count <= '0;
            fire  <= 1'b0;
        end else if (count == LAST) begin
            count <= '0;
            fire  <= 1'b1;
        end else begin
            count <= count + 1'b1;
            fire  <= 1'b0;
        end
    end

endmodule

// File: rtl/nes_pad_scheduler.sv
// Two-player NES pad poller: latch/clock sequencing, parallel deserialisation,
// per-frame button words with press/release edges.
module nes_pad_scheduler
    import nes_pad_pkg::*;
#(
    parameter int HALF_CYC        = 128,
    parameter int POLL_PERIOD_CYC = 200000,
    parameter int NBITS           = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       poll_req,
    input  logic       auto_en,
    input  logic       pad_data0,
    input  logic       pad_data1,
    output logic       pad_latch,
    output logic       pad_clock,
    output logic [7:0] buttons0,
    output logic [7:0] buttons1,
    output logic [7:0] pressed0,
    output logic [7:0] pressed1,
    output logic [7:0] released0,
    output logic [7:0] released1,
    output logic       valid,
    output logic       busy
);

    generate
        if (NBITS != 8) begin : g_nbits_check
            $error("nes_pad_scheduler: NBITS must be 8");
        end
    endgenerate

    localparam int PH_W = $clog2(2 * HALF_CYC);
    localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(HALF_CYC - 1);
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(2 * HALF_CYC - 1);

    state_t          state;
    logic [PH_W-1:0] phase;
    logic [2:0]      slot;
    logic            pending;
    logic            timer_fire;
    logic            trigger;
    logic            sample_en;
    logic            publish_en;
    logic [1:0]      data_in;

    logic [1:0][NBITS-1:0] btn_all;
    logic [1:0][NBITS-1:0] prs_all;
    logic [1:0][NBITS-1:0] rel_all;

    nes_poll_timer #(
        .POLL_PERIOD_CYC(POLL_PERIOD_CYC)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .auto_en (auto_en),
        .fire    (timer_fire)
    );

    assign trigger    = poll_req | timer_fire;
    assign sample_en  = (state == SHIFT) && (phase == PH_SAMPLE);
    assign publish_en = (state == SHIFT) && (phase == PH_LAST) && (slot == 3'd7);
    assign busy       = (state != IDLE);
    assign data_in    = {pad_data1, pad_data0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase     <= '0;
            slot      <= '0;
            pending   <= 1'b0;
            pad_latch <= 1'b0;
            pad_clock <= 1'b0;
            valid     <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger || pending) begin
                        state     <= LATCH;
                        phase     <= '0;
                        pending   <= 1'b0;
                        pad_latch <= 1'b1;
                    end
                end
                LATCH: begin
                    pending <= pending | trigger;
                    if (phase == PH_LAST) begin
                        state     <= SHIFT;
                        phase     <= '0;
                        slot      <= '0;
                        pad_latch <= 1'b0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                SHIFT: begin
                    pending <= pending | trigger;
                    // the last slot has no rising edge: 8 samples need only 7 shifts
                    if (phase == PH_SAMPLE && slot != 3'd7)
                        pad_clock <= 1'b1;
                    if (phase == PH_LAST) begin
                        pad_clock <= 1'b0;
                        phase     <= '0;
                        if (slot == 3'd7) begin
                            state <= DONE;
                            valid <= 1'b1;
                        end else begin
                            slot <= slot + 1'b1;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                DONE: begin
                    pending <= pending | trigger;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output words are loaded on the edge into DONE so they appear alongside valid.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_pad
            logic [NBITS-1:0] shift_reg;
            logic [NBITS-1:0] btn;
            logic [NBITS-1:0] prs;
            logic [NBITS-1:0] rel;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shift_reg <= '0;
                    btn       <= '0;
                    prs       <= '0;
                    rel       <= '0;
                end else begin
                    if (sample_en)
                        shift_reg <= {shift_reg[NBITS-2:0], data_in[gi]};
                    if (publish_en) begin
                        btn <= ~shift_reg;
                        prs <= ~shift_reg & ~btn;
                        rel <= shift_reg & btn;
                    end
                end
            end

            assign btn_all[gi] = btn;
            assign prs_all[gi] = prs;
            assign rel_all[gi] = rel;
        end
    endgenerate

    assign buttons0  = btn_all[0];
    assign buttons1  = btn_all[1];
    assign pressed0  = prs_all[0];
    assign pressed1  = prs_all[1];
    assign released0 = rel_all[0];
    assign released1 = rel_all[1];

endmodule
